// File: rtl/age_tracker_victim.sv
// Per-line validity, saturating age and granularity sub-counter for one cache set,
// with a registered replacement victim (first invalid line, else oldest line).
module age_tracker_victim #(
    parameter int LINES = 32,
    parameter int IW    = $clog2(LINES),
    parameter int K     = 3,
    parameter int J     = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [J-1:0]       gran,
    input  logic               acc_valid,
    input  logic               acc_hit,
    input  logic [IW-1:0]      acc_idx,
    input  logic               fill_valid,
    input  logic [IW-1:0]      fill_idx,
    input  logic               inv_valid,
    input  logic [IW-1:0]      inv_idx,
    output logic [LINES*K-1:0] age_flat,
    output logic [LINES-1:0]   valid_vec,
    output logic [IW-1:0]      victim_idx,
    output logic               victim_inv
);

    logic [LINES*J-1:0] sub_q;
    logic [LINES*K-1:0] age_d;
    logic [LINES*J-1:0] sub_d;
    logic [LINES-1:0]   valid_d;
    logic [IW-1:0]      victim_d;
    logic               victim_inv_d;

    logic [K:0]         age_inc;
    logic [K-1:0]       best_age;

    // Per-line next state; priority on one index is fill > invalidate > hit > aging.
    always_comb begin
        age_d   = age_flat;
        sub_d   = sub_q;
        valid_d = valid_vec;
        age_inc = '0;
        for (int unsigned i = 0; i < LINES; i++) begin
            age_inc = {1'b0, age_flat[i*K +: K]} + 1'b1;
            if (fill_valid && (fill_idx == IW'(i))) begin
                age_d[i*K +: K] = '0;
                sub_d[i*J +: J] = '0;
                valid_d[i]      = 1'b1;
            end else if (inv_valid && (inv_idx == IW'(i))) begin
                age_d[i*K +: K] = '1;
                valid_d[i]      = 1'b0;
            end else if (acc_valid && acc_hit && (acc_idx == IW'(i))) begin
                age_d[i*K +: K] = '0;
                sub_d[i*J +: J] = '0;
            end else if (acc_valid) begin
                if (sub_q[i*J +: J] >= gran) begin
                    sub_d[i*J +: J] = '0;
                    age_d[i*K +: K] = age_inc[K] ? '1 : age_inc[K-1:0];
                end else begin
                    sub_d[i*J +: J] = sub_q[i*J +: J] + 1'b1;
                end
            end
        end
    end

    // Victim from next-state values: lowest invalid line, else oldest with ties to lowest index.
    always_comb begin
        victim_d     = '0;
        victim_inv_d = 1'b0;
        best_age     = age_d[K-1:0];
        for (int unsigned i = 0; i < LINES; i++) begin
            if (!victim_inv_d && !valid_d[i]) begin
                victim_inv_d = 1'b1;
                victim_d     = IW'(i);
            end
        end
        if (!victim_inv_d) begin
            for (int unsigned i = 1; i < LINES; i++) begin
                if (age_d[i*K +: K] > best_age) begin
                    best_age = age_d[i*K +: K];
                    victim_d = IW'(i);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            age_flat   <= '0;
            sub_q      <= '0;
            valid_vec  <= '0;
            victim_idx <= '0;
            victim_inv <= 1'b1;
        end else begin
            age_flat   <= age_d;
            sub_q      <= sub_d;
            valid_vec  <= valid_d;
            victim_idx <= victim_d;
            victim_inv <= victim_inv_d;
        end
    end

endmodule

// File: tb/tb_age_tracker_victim.sv
// Directed bench for age_tracker_victim: behavioural line model checked every cycle,
// plus hand-computed expectations from the test plan.
module tb_age_tracker_victim;

    localparam int LINES = 32;
    localparam int IW    = 5;
    localparam int K     = 3;
    localparam int J     = 4;
    localparam int AMAX  = (1 << K) - 1;

    logic               clk;
    logic               rst_n;
    logic [J-1:0]       gran;
    logic               acc_valid;
    logic               acc_hit;
    logic [IW-1:0]      acc_idx;
    logic               fill_valid;
    logic [IW-1:0]      fill_idx;
    logic               inv_valid;
    logic [IW-1:0]      inv_idx;
    logic [LINES*K-1:0] age_flat;
    logic [LINES-1:0]   valid_vec;
    logic [IW-1:0]      victim_idx;
    logic               victim_inv;

    int checks   = 0;
    int failures = 0;

    age_tracker_victim #(.LINES(LINES), .IW(IW), .K(K), .J(J)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .gran       (gran),
        .acc_valid  (acc_valid),
        .acc_hit    (acc_hit),
        .acc_idx    (acc_idx),
        .fill_valid (fill_valid),
        .fill_idx   (fill_idx),
        .inv_valid  (inv_valid),
        .inv_idx    (inv_idx),
        .age_flat   (age_flat),
        .valid_vec  (valid_vec),
        .victim_idx (victim_idx),
        .victim_inv (victim_inv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: one integer age/sub and a valid flag per line.
    int m_age [LINES];
    int m_sub [LINES];
    bit m_val [LINES];
    int m_vidx;
    bit m_vinv;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            foreach (m_age[i]) begin
                m_age[i] = 0;
                m_sub[i] = 0;
                m_val[i] = 0;
            end
            m_vidx = 0;
            m_vinv = 1;
        end else begin
            foreach (m_age[i]) begin
                if (fill_valid && int'(fill_idx) == i) begin
                    m_age[i] = 0;
                    m_sub[i] = 0;
                    m_val[i] = 1;
                end else if (inv_valid && int'(inv_idx) == i) begin
                    m_age[i] = AMAX;
                    m_val[i] = 0;
                end else if (acc_valid && acc_hit && int'(acc_idx) == i) begin
                    m_age[i] = 0;
                    m_sub[i] = 0;
                end else if (acc_valid) begin
                    if (m_sub[i] >= int'(gran)) begin
                        m_sub[i] = 0;
                        m_age[i] = (m_age[i] + 1 > AMAX) ? AMAX : m_age[i] + 1;
                    end else begin
                        m_sub[i] = m_sub[i] + 1;
                    end
                end
            end
            m_vinv = 0;
            m_vidx = -1;
            foreach (m_val[i])
                if (m_vidx < 0 && !m_val[i]) m_vidx = i;
            if (m_vidx >= 0) begin
                m_vinv = 1;
            end else begin
                int best;
                best   = -1;
                foreach (m_age[i])
                    if (m_age[i] > best) begin
                        best   = m_age[i];
                        m_vidx = i;
                    end
            end
        end
    end

    // Every-cycle comparison of registered outputs against the model.
    always @(negedge clk) begin
        logic [LINES*K-1:0] e_age;
        logic [LINES-1:0]   e_val;
        foreach (m_age[i]) begin
            e_age[i*K +: K] = K'(m_age[i]);
            e_val[i]        = m_val[i];
        end
        check("model_age_flat", 128'(age_flat), 128'(e_age));
        check("model_valid_vec", 128'(valid_vec), 128'(e_val));
        check("model_victim_idx", 128'(victim_idx), 128'(m_vidx));
        check("model_victim_inv", 128'(victim_inv), 128'(m_vinv));
    end

    task automatic cyc(input bit av, input bit ah, input int ai,
                       input bit fv, input int fi, input bit iv, input int ii);
        acc_valid  = av;
        acc_hit    = ah;
        acc_idx    = IW'(ai);
        fill_valid = fv;
        fill_idx   = IW'(fi);
        inv_valid  = iv;
        inv_idx    = IW'(ii);
        @(negedge clk);
    endtask

    task automatic miss(input int n);
        for (int m = 0; m < n; m++) cyc(1, 0, 0, 0, 0, 0, 0);
    endtask

    logic [LINES*K-1:0] e;

    initial begin
        rst_n = 1'b1;
        gran = '0;
        acc_valid = 0; acc_hit = 0; acc_idx = '0;
        fill_valid = 0; fill_idx = '0; inv_valid = 0; inv_idx = '0;
        #1 rst_n = 1'b0;
        #1;
        check("reset_age", 128'(age_flat), 128'(0));
        check("reset_valid", 128'(valid_vec), 128'(0));
        check("reset_victim_idx", 128'(victim_idx), 128'(0));
        check("reset_victim_inv", 128'(victim_inv), 128'(1));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 1: fill every line with no accesses
        for (int i = 0; i < LINES; i++) cyc(0, 0, 0, 1, i, 0, 0);
        check("t1_age", 128'(age_flat), 128'(0));
        check("t1_valid", 128'(valid_vec), 128'(32'hFFFF_FFFF));
        check("t1_victim_idx", 128'(victim_idx), 128'(0));
        check("t1_victim_inv", 128'(victim_inv), 128'(0));

        // 2: gran=2, nine misses then a hit on line 5
        gran = 4'd2;
        miss(9);
        e = {32{3'd3}};
        check("t2_age_after_misses", 128'(age_flat), 128'(e));
        cyc(1, 1, 5, 0, 0, 0, 0);
        e[15 +: 3] = 3'd0;
        check("t2_age_after_hit", 128'(age_flat), 128'(e));
        check("t2_victim_idx", 128'(victim_idx), 128'(0));

        // 3: gran=0 saturation, then refresh line 0
        gran = 4'd0;
        miss(10);
        e = {32{3'd7}};
        check("t3_saturated", 128'(age_flat), 128'(e));
        cyc(1, 1, 0, 0, 0, 0, 0);
        miss(3);
        check("t3_age0", 128'(age_flat[2:0]), 128'(3));
        check("t3_victim_idx", 128'(victim_idx), 128'(1));

        // 4: invalidate beats hit on line 9; then fill 9 with a miss
        cyc(1, 1, 9, 0, 0, 1, 9);
        check("t4_valid9", 128'(valid_vec[9]), 128'(0));
        check("t4_age9", 128'(age_flat[27 +: 3]), 128'(7));
        check("t4_victim_idx", 128'(victim_idx), 128'(9));
        check("t4_victim_inv", 128'(victim_inv), 128'(1));
        cyc(1, 0, 0, 1, 9, 0, 0);
        check("t4_fill_age9", 128'(age_flat[27 +: 3]), 128'(0));
        check("t4_fill_valid9", 128'(valid_vec[9]), 128'(1));
        check("t4_age0_aged", 128'(age_flat[2:0]), 128'(5));
        check("t4_victim_inv_after_fill", 128'(victim_inv), 128'(0));

        // 5: sub=5 under gran=7, then lowering gran to 3 ages at once
        gran = 4'd7;
        miss(5);
        check("t5_no_age_yet", 128'(age_flat[2:0]), 128'(5));
        gran = 4'd3;
        miss(1);
        check("t5_age0", 128'(age_flat[2:0]), 128'(6));
        check("t5_age9", 128'(age_flat[27 +: 3]), 128'(1));
        gran = 4'd9;
        cyc(0, 0, 0, 0, 0, 0, 0);
        check("t5_idle_hold", 128'(age_flat[2:0]), 128'(6));
        gran = 4'd3;
        miss(1);
        check("t5_sub_was_cleared", 128'(age_flat[2:0]), 128'(6));

        // 6: asynchronous reset during a burst of misses
        gran = 4'd0;
        acc_valid = 1; acc_hit = 0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_async_age", 128'(age_flat), 128'(0));
        check("t6_async_valid", 128'(valid_vec), 128'(0));
        check("t6_async_victim_inv", 128'(victim_inv), 128'(1));
        check("t6_async_victim_idx", 128'(victim_idx), 128'(0));
        @(negedge clk);
        @(negedge clk);
        #1 rst_n = 1'b1;
        #1;
        check("t6_hold_until_edge", 128'(age_flat), 128'(0));
        check("t6_hold_victim_inv", 128'(victim_inv), 128'(1));
        @(negedge clk);
        e = {32{3'd1}};
        check("t6_first_update", 128'(age_flat), 128'(e));
        acc_valid = 0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/age_tracker_victim.md
Name: age_tracker_victim

Overview:
Parametrised successor to the per-line age/set-counter tracker used by the EVA replacement logic. It tracks validity, a saturating age and a granularity sub-counter for every line of one cache set. Aging granularity is set at run time, and fill, hit and invalidate events are accepted in the same cycle. It also computes a registered victim index (first invalid line, else the oldest line) for the cache controller's refill path.

Parameters:
LINES, 32, number of tracked lines (power of 2, 2..64)
IW, $clog2(LINES), line index width
K, 3, age width; ages saturate at 2^K-1
J, 4, granularity sub-counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
gran  in  J  aging granularity G; age advances once every G+1 aging events
acc_valid  in  1  cache access completed this cycle (aging event)
acc_hit  in  1  access hit; qualifies acc_idx
acc_idx  in  IW  line hit by the access
fill_valid  in  1  line written by refill
fill_idx  in  IW  refilled line
inv_valid  in  1  line invalidate
inv_idx  in  IW  invalidated line
age_flat  out  LINES*K  registered ages; line i at [i*K +: K]
valid_vec  out  LINES  registered per-line valid bits
victim_idx  out  IW  registered replacement candidate
victim_inv  out  1  victim_idx is an invalid line

Behaviour:
- Reset (async, rst_n=0): all age=0, sub=0, valid=0; age_flat=0, valid_vec=0, victim_idx=0, victim_inv=1. Reset takes effect mid-operation immediately; the first update is on the first rising edge after rst_n rises.
- All state updates occur on the rising clk edge. Outputs are registers and show post-update state one cycle after the event.
- Aging event (acc_valid=1), evaluated for every line i not "touched" this cycle:
  - if sub[i] >= gran: sub[i] <= 0, and age[i] <= age[i]+1, saturating at 2^K-1 (a saturated line still resets sub);
  - else sub[i] <= sub[i]+1.
  - The >= comparison makes a run-time reduction of gran take effect at once. gran=0 ages on every event.
  - Aging applies to valid and invalid lines alike.
- Touched line: acc_valid & acc_hit at acc_idx, or fill_valid at fill_idx. A touched line gets age <= 0, sub <= 0 and does not age this cycle. A fill also sets valid <= 1.
- A miss (acc_valid=1, acc_hit=0) ages all lines. acc_idx is ignored on a miss.
- Invalidate: valid[inv_idx] <= 0 and age[inv_idx] <= 2^K-1 (sub unchanged).
- Priority on the same index in one cycle: fill > invalidate > hit > aging. Different indices update independently in the same cycle.
- No event (all valids 0): state holds. A change in gran alone changes nothing.
- Victim selection (combinational on next-state values, then registered):
  - if any line is invalid: the lowest-index invalid line, victim_inv=1;
  - else the line with maximum age, ties to lowest index, victim_inv=0.
  - Latency: victim reflects the cycle-N events at cycle N+1.
- Widths:
  - sub and gran are both J bits, unsigned compare.
  - Age increment is computed K+1 wide and clamped.
  - Index inputs are always in range (LINES is a power of 2).
- No combinational path exists from inputs to outputs.

Test Plan:
1. Reset, then fill lines 0..31 in order with gran=0, no accesses. Required: all ages 0, valid_vec=all ones, victim_idx=0, victim_inv=0.
2. gran=2: 9 misses. Required: every age=3 (increments on misses 3, 6, 9) and sub=0. Then a hit on line 5: age[5]=0 and the others stay at 3 with sub=1. Victim: 0.
3. gran=0, K=3: 10 misses. Required: all ages saturate at 7 with no wrap. Then hit line 0 and run 3 more misses: age[0]=3, victim_idx=1.
4. Invalidate line 9 while hitting line 9 in the same cycle. Required: valid[9]=0, age[9]=7, victim_idx=9, victim_inv=1. Then fill 9 together with a miss: age[9]=0, valid[9]=1, all other lines aged.
5. gran=7 with sub=5 on all lines, then switch gran to 3 and issue 1 miss. Required: age increments on that miss and sub=0.
6. Assert rst_n low asynchronously mid-burst, between clock edges. Required: outputs go to their reset values immediately (age_flat=0, valid_vec=0, victim_inv=1) and stay there until the first edge after release.
